alu_exec_pipe: RTL and testbench

ALU_EXEC_PIPE -- requirements
Module: alu_exec_pipe

---
 rtl/alu_exec_pipe.sv | 254 +++++++++++++++++++++++++
 tb/tb_alu_exec_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_pipe.sv
// Operation IDs shared by the execute pipe and anything that drives it.
package alu_exec_pipe_pkg;
  localparam int unsigned OP_LUI   = 1;
  localparam int unsigned OP_AUIPC = 2;
  localparam int unsigned OP_JAL   = 3;
  localparam int unsigned OP_JALR  = 4;
  localparam int unsigned OP_BEQ   = 5;
  localparam int unsigned OP_BNE   = 6;
  localparam int unsigned OP_BLT   = 7;
  localparam int unsigned OP_BGE   = 8;
  localparam int unsigned OP_BLTU  = 9;
  localparam int unsigned OP_BGEU  = 10;
  localparam int unsigned OP_ADD   = 11;
  localparam int unsigned OP_SUB   = 12;
  localparam int unsigned OP_SLL   = 13;
  localparam int unsigned OP_SLT   = 14;
  localparam int unsigned OP_SLTU  = 15;
  localparam int unsigned OP_XOR   = 16;
  localparam int unsigned OP_SRL   = 17;
  localparam int unsigned OP_SRA   = 18;
  localparam int unsigned OP_OR    = 19;
  localparam int unsigned OP_AND   = 20;
  localparam int unsigned OP_ADDI  = 21;
  localparam int unsigned OP_SLTI  = 22;
  localparam int unsigned OP_SLTIU = 23;
  localparam int unsigned OP_XORI  = 24;
  localparam int unsigned OP_ORI   = 25;
  localparam int unsigned OP_ANDI  = 26;
  localparam int unsigned OP_SLLI  = 27;
  localparam int unsigned OP_SRLI  = 28;
  localparam int unsigned OP_SRAI  = 29;
endpackage

// Single-issue ALU execute pipe: computes in stage 1, delays through STAGES-1
// registers, then buffers results in a credit-managed in-order result queue.
module alu_exec_pipe
  import alu_exec_pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ROB_ID_W = 4,
  parameter int unsigned OP_W     = 6,
  parameter int unsigned STAGES   = 2,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     in_op,
  input  logic [DATA_W-1:0]   in_pc,
  input  logic [DATA_W-1:0]   in_rs1,
  input  logic [DATA_W-1:0]   in_rs2,
  input  logic [DATA_W-1:0]   in_imm,
  input  logic [ROB_ID_W-1:0] in_rob_id,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ROB_ID_W-1:0] out_rob_id,
  output logic [DATA_W-1:0]   out_value,
  output logic [DATA_W-1:0]   out_target_pc,
  output logic                out_jump,
  input  logic                roll_back,
  output logic                busy
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned CW = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic [DATA_W-1:0]   value;
    logic [DATA_W-1:0]   target;
    logic                jump;
  } res_t;

  logic        accept;
  logic        pop;
  logic        push;
  res_t        push_data;
  logic [2:0]  inflight;

  // ---------------------------------------------------------------- compute
  logic [31:0]       op_sel;
  logic              imm_form;
  logic [DATA_W-1:0] opb;
  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] pc_imm;
  logic [DATA_W-1:0] jalr_sum;
  logic [4:0]        shamt;
  logic              take;
  logic              lt_s;
  logic              lt_u;
  res_t              calc;

  always_comb begin
    op_sel   = 32'(in_op);
    imm_form = (op_sel >= OP_ADDI) && (op_sel <= OP_SRAI);
    opb      = imm_form ? in_imm : in_rs2;
    shamt    = opb[4:0];
    pc_plus4 = in_pc + DATA_W'(4);
    pc_imm   = in_pc + in_imm;
    jalr_sum = in_rs1 + in_imm;
    lt_s     = $signed(in_rs1) < $signed(opb);
    lt_u     = in_rs1 < opb;

    case (op_sel)
      OP_BEQ:  take = in_rs1 == in_rs2;
      OP_BNE:  take = in_rs1 != in_rs2;
      OP_BLT:  take = $signed(in_rs1) < $signed(in_rs2);
      OP_BGE:  take = $signed(in_rs1) >= $signed(in_rs2);
      OP_BLTU: take = in_rs1 < in_rs2;
      OP_BGEU: take = in_rs1 >= in_rs2;
      default: take = 1'b0;
    endcase

    calc        = '0;
    calc.rob_id = in_rob_id;
    calc.target = pc_plus4;
    case (op_sel)
      OP_LUI:   calc.value = in_imm;
      OP_AUIPC: calc.value = pc_imm;
      OP_JAL: begin
        calc.value  = pc_plus4;
        calc.target = pc_imm;
        calc.jump   = 1'b1;
      end
      OP_JALR: begin
        calc.value  = pc_plus4;
        calc.target = {jalr_sum[DATA_W-1:1], 1'b0};
        calc.jump   = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        calc.value  = DATA_W'(take);
        calc.target = pc_imm;
        calc.jump   = take;
      end
      OP_ADD, OP_ADDI:   calc.value = in_rs1 + opb;
      OP_SUB:            calc.value = in_rs1 - opb;
      OP_SLL, OP_SLLI:   calc.value = in_rs1 << shamt;
      OP_SLT, OP_SLTI:   calc.value = DATA_W'(lt_s);
      OP_SLTU, OP_SLTIU: calc.value = DATA_W'(lt_u);
      OP_XOR, OP_XORI:   calc.value = in_rs1 ^ opb;
      OP_SRL, OP_SRLI:   calc.value = in_rs1 >> shamt;
      OP_SRA, OP_SRAI:   calc.value = $unsigned($signed(in_rs1) >>> shamt);
      OP_OR, OP_ORI:     calc.value = in_rs1 | opb;
      OP_AND, OP_ANDI:   calc.value = in_rs1 & opb;
      default:           calc.value = '0;
    endcase
  end

  // --------------------------------------------------------------- pipeline
  // With one stage the computed result is written into the queue directly.
  if (STAGES == 1) begin : g_direct
    assign push      = accept;
    assign push_data = calc;
    assign inflight  = '0;
  end else begin : g_pipe
    logic [STAGES-2:0] vld_q;
    res_t              dat_q [STAGES-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
      end else if (rdy) begin
        if (roll_back) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= accept;
          for (int unsigned i = 1; i < STAGES - 1; i++) begin
            vld_q[i] <= vld_q[i-1];
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rdy) begin
        dat_q[0] <= calc;
        for (int unsigned i = 1; i < STAGES - 1; i++) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end

    always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < STAGES - 1; i++) begin
        inflight = inflight + 3'(vld_q[i]);
      end
    end

    assign push      = vld_q[STAGES-2] & rdy & ~roll_back;
    assign push_data = dat_q[STAGES-2];
  end

  // ------------------------------------------------------------ result queue
  res_t          mem_q [QDEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  res_t          head;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (rdy) begin
      if (roll_back) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push) begin
          wr_q <= wr_q + AW'(1);
        end
        if (pop) begin
          rd_q <= rd_q + AW'(1);
        end
        cnt_q <= cnt_d;
      end
    end
  end

  // Credits count both queued and in-flight results, so a push never finds the queue full.
  assign in_ready = (32'(inflight) + 32'(cnt_q)) < QDEPTH;
  assign accept   = in_valid & in_ready & rdy & ~roll_back;
  assign out_valid = cnt_q != '0;
  assign pop      = out_valid & out_ready & rdy & ~roll_back;
  assign busy     = (inflight != '0) || out_valid;

  assign head          = mem_q[rd_q];
  assign out_rob_id    = out_valid ? head.rob_id : '0;
  assign out_value     = out_valid ? head.value  : '0;
  assign out_target_pc = out_valid ? head.target : '0;
  assign out_jump      = out_valid ? head.jump   : 1'b0;

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Scoreboard bench for alu_exec_pipe: a behavioural model predicts results and
// occupancy; a negedge monitor compares every cycle the DUT presents.
module tb_alu_exec_pipe;
  import alu_exec_pipe_pkg::*;

  localparam int unsigned STAGES = 2;
  localparam int unsigned QDEPTH = 4;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [31:0] in_pc;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [31:0] in_imm;
  logic [3:0]  in_rob_id;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_rob_id;
  logic [31:0] out_value;
  logic [31:0] out_target_pc;
  logic        out_jump;
  logic        roll_back;
  logic        busy;

  alu_exec_pipe #(
    .DATA_W(32), .ROB_ID_W(4), .OP_W(6), .STAGES(STAGES), .QDEPTH(QDEPTH)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rob_id(in_rob_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_rob_id(out_rob_id),
    .out_value(out_value), .out_target_pc(out_target_pc), .out_jump(out_jump),
    .roll_back(roll_back), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  rob;
    logic [31:0] value;
    logic [31:0] target;
    logic        jump;
    int unsigned edge_no;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned ecount = 0;
  bit          mon_en = 0;
  bit          mon_vis;

  int unsigned ops[31] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BEQ, OP_BNE, OP_BLT,
                           OP_BGE, OP_BLTU, OP_BGEU, OP_ADD, OP_SUB, OP_SLL, OP_SLT,
                           OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND, OP_ADDI,
                           OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI,
                           OP_SRLI, OP_SRAI, 0, 45};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference semantics written straight from the instruction rules.
  function automatic exp_t model(input int unsigned op, input logic [31:0] pc,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [31:0] imm, input logic [3:0] rob);
    exp_t        e;
    logic [31:0] b;
    int unsigned sh;
    bit          c;
    bit          br;
    e.rob = rob; e.value = 0; e.target = pc + 4; e.jump = 0; e.edge_no = 0;
    b  = (op >= OP_ADDI && op <= OP_SRAI) ? imm : rs2;
    sh = b % 32;
    c  = 0;
    br = 0;
    case (op)
      OP_LUI:   e.value = imm;
      OP_AUIPC: e.value = pc + imm;
      OP_JAL:   begin e.value = pc + 4; e.target = pc + imm; e.jump = 1; end
      OP_JALR:  begin e.value = pc + 4; e.target = (rs1 + imm) & 32'hFFFF_FFFE; e.jump = 1; end
      OP_BEQ:   begin br = 1; c = (rs1 == rs2); end
      OP_BNE:   begin br = 1; c = (rs1 != rs2); end
      OP_BLT:   begin br = 1; c = (int'(rs1) < int'(rs2)); end
      OP_BGE:   begin br = 1; c = !(int'(rs1) < int'(rs2)); end
      OP_BLTU:  begin br = 1; c = (rs1 < rs2); end
      OP_BGEU:  begin br = 1; c = !(rs1 < rs2); end
      OP_ADD, OP_ADDI:   e.value = rs1 + b;
      OP_SUB:            e.value = rs1 - b;
      OP_SLL, OP_SLLI:   e.value = rs1 << sh;
      OP_SLT, OP_SLTI:   e.value = (int'(rs1) < int'(b)) ? 1 : 0;
      OP_SLTU, OP_SLTIU: e.value = (rs1 < b) ? 1 : 0;
      OP_XOR, OP_XORI:   e.value = rs1 ^ b;
      OP_SRL, OP_SRLI:   e.value = rs1 >> sh;
      OP_SRA, OP_SRAI:   e.value = (rs1 >> sh) | (rs1[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      OP_OR, OP_ORI:     e.value = rs1 | b;
      OP_AND, OP_ANDI:   e.value = rs1 & b;
      default:           e.value = 0;
    endcase
    if (br) begin
      e.value  = c ? 1 : 0;
      e.target = pc + imm;
      e.jump   = c;
    end
    return e;
  endfunction

  // Stimulus-side bookkeeping: predicts what the coming edge does to the outstanding set.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      exp_q.delete();
    end else if (rdy) begin
      ecount++;
      if (roll_back) begin
        exp_q.delete();
      end else if (in_valid && in_ready) begin
        e = model(32'(in_op), in_pc, in_rs1, in_rs2, in_imm, in_rob_id);
        e.edge_no = ecount;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: compares the presented head and occupancy flags, pops on a real handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_vis = (exp_q.size() > 0) && (ecount >= exp_q[0].edge_no + STAGES - 1);
      chk("in_ready", in_ready, exp_q.size() < QDEPTH);
      chk("busy", busy, exp_q.size() != 0);
      chk("out_valid", out_valid, mon_vis);
      if (mon_vis && out_valid) begin
        chk("out_rob_id", out_rob_id, exp_q[0].rob);
        chk("out_value", out_value, exp_q[0].value);
        chk("out_target_pc", out_target_pc, exp_q[0].target);
        chk("out_jump", out_jump, exp_q[0].jump);
        if (out_ready && rdy && !roll_back && !rst) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int unsigned op, input logic [31:0] pc, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] imm, input logic [3:0] rob);
    in_op = 6'(op); in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_rob_id = rob;
  endtask

  task automatic rand_in();
    logic [31:0] a;
    logic [31:0] b;
    a = ($urandom % 4 == 0) ? ($urandom % 8) : $urandom;
    b = ($urandom % 4 == 0) ? a : (($urandom % 3 == 0) ? ($urandom % 40) : $urandom);
    set_in(ops[$urandom_range(0, 30)], $urandom & 32'hFFFF_FFFC, a, b,
           ($urandom % 2 == 0) ? 32'($signed(12'($urandom))) : $urandom, 4'($urandom));
  endtask

  // Holds in_valid until the block accepts, bounded.
  task automatic issue();
    int unsigned n = 0;
    in_valid = 1'b1;
    while (!(in_ready && rdy && !roll_back) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    in_valid = 0; out_ready = 1; rdy = 1; roll_back = 0; rst = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still outstanding, required 0", exp_q.size());
    end
  endtask

  // Checks exact latency and explicit result values for one instruction into an empty queue.
  task automatic directed(input int unsigned op, input logic [31:0] pc, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] imm, input logic [3:0] rob,
                          input logic [31:0] v, input logic [31:0] t, input logic j);
    drain();
    out_ready = 0;
    set_in(op, pc, rs1, rs2, imm, rob);
    issue();
    for (int unsigned k = 1; k < STAGES; k++) begin
      chk("dir_latency_early", out_valid, 0);
      step();
    end
    chk("dir_out_valid", out_valid, 1);
    chk("dir_value", out_value, v);
    chk("dir_target", out_target_pc, t);
    chk("dir_jump", out_jump, j);
    chk("dir_rob", out_rob_id, rob);
    out_ready = 1;
    step();
  endtask

  initial begin
    int unsigned acc;
    int unsigned n;
    rst = 1; rdy = 1; in_valid = 0; out_ready = 0; roll_back = 0;
    set_in(0, 0, 0, 0, 0, 0);
    step(); step();
    rst = 0;
    mon_en = 1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_value", out_value, 0);
    chk("rst_out_rob_id", out_rob_id, 0);
    chk("rst_out_target", out_target_pc, 0);
    chk("rst_out_jump", out_jump, 0);

    directed(OP_ADDI, 32'h200, 5, 0, 32'hFFFF_FFFD, 2, 2, 32'h204, 0);
    directed(OP_SRA, 32'h10, 32'h8000_0000, 32'h24, 0, 3, 32'hF800_0000, 32'h14, 0);
    directed(OP_SLTU, 32'h20, 1, 32'hFFFF_FFFF, 0, 4, 1, 32'h24, 0);
    directed(OP_BLT, 32'h100, 32'hFFFF_FFFF, 1, 32'h20, 5, 1, 32'h120, 1);
    directed(OP_JALR, 32'h40, 32'h1003, 0, 4, 6, 32'h44, 32'h1006, 1);
    directed(45, 32'h80, 7, 9, 3, 7, 0, 32'h84, 0);

    // Credit limit: six offered with the output stalled.
    drain();
    out_ready = 0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      if (acc < 6) begin in_valid = 1; rand_in(); end else in_valid = 0;
      n = (in_valid && in_ready) ? 1 : 0;
      step();
      acc += n;
      in_valid = 0;
    end
    chk("credit_accepts", acc, QDEPTH);
    chk("credit_in_ready", in_ready, 0);
    out_ready = 1;
    for (int c = 0; c < 60 && acc < 6; c++) begin
      in_valid = 1; rand_in();
      n = in_ready ? 1 : 0;
      step();
      acc += n;
      in_valid = 0;
    end
    chk("credit_all_accepted", acc, 6);

    // Flush with results both queued and in flight; concurrent accept and pop are void.
    drain();
    out_ready = 0;
    for (int c = 0; c < 3; c++) begin rand_in(); issue(); end
    roll_back = 1; in_valid = 1; out_ready = 1; rand_in();
    step();
    roll_back = 0; in_valid = 0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_busy", busy, 0);
    chk("flush_in_ready", in_ready, 1);
    repeat (8) step();

    // Freeze: rdy low with a waiting result; accept and roll_back must be ignored.
    drain();
    out_ready = 0;
    set_in(OP_ADD, 32'h300, 7, 9, 0, 9);
    issue();
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    rdy = 0; out_ready = 1; roll_back = 1; in_valid = 1; rand_in();
    for (int c = 0; c < 3; c++) begin
      step();
      chk("freeze_out_valid", out_valid, 1);
      chk("freeze_value", out_value, 16);
      chk("freeze_rob", out_rob_id, 9);
    end
    rdy = 1; roll_back = 0; in_valid = 0;
    step();
    chk("freeze_pop_resumed", out_valid, 0);

    // Reset mid-operation with rdy low and roll_back high.
    drain();
    out_ready = 0;
    for (int c = 0; c < 3; c++) begin rand_in(); issue(); end
    rst = 1; rdy = 0; roll_back = 1;
    step();
    rst = 0; rdy = 1; roll_back = 0; out_ready = 1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_value", out_value, 0);
    chk("midrst_out_jump", out_jump, 0);
    repeat (8) step();

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom % 3) != 0;
      rand_in();
      out_ready = ($urandom % 4) != 0;
      rdy       = ($urandom % 8) != 0;
      roll_back = ($urandom % 50) == 0;
      rst       = ($urandom % 300) == 0;
      step();
    end
    drain();
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
